// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master arbiter for the student-record register slave
//
// Ports:
//   PCLK, PRESETn                      clock, synchronous active-low reset
//   req_valid/req_write [NREQ]         per-requester request strobe and direction
//   req_addr/req_wdata  [32*NREQ]      packed per-requester address and write data
//   req_ack/rsp_done    [NREQ]         one-hot single-cycle accept / completion pulses
//   rsp_rdata [32], rsp_err            completion data and timeout flag
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs
//   PRDATA/PREADY                      APB slave inputs
// Optional: APB_ARB_TIMEOUT_EN enables the ACCESS-phase PREADY timeout.
module apb_master_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      rsp_done,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;

    logic          pick_found;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic [IW-1:0] next_ptr;
    logic [31:0]   pick_addr;
    logic [31:0]   pick_wdata;
    logic          pick_write;

    // Scan requesters starting at rr_ptr and wrapping; the first pending one wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        next_ptr   = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_write = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
                next_ptr   = IW'((int'(idx) + 1) % NREQ);
                pick_addr  = req_addr[idx*32 +: 32];
                pick_wdata = req_wdata[idx*32 +: 32];
                pick_write = req_write[idx];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            req_ack   <= '0;
            rsp_done  <= '0;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            req_ack  <= '0;
            rsp_done <= '0;
            case (state)
                ST_IDLE: begin
                    // Address/data/direction are only loaded on a grant, so they
                    // stay stable through SETUP and every ACCESS wait cycle.
                    if (pick_found) begin
                        grant   <= pick;
                        rr_ptr  <= next_ptr;
                        PADDR   <= pick_addr;
                        PWDATA  <= pick_wdata;
                        PWRITE  <= pick_write;
                        req_ack <= NREQ'(1) << pick;
                        PSEL    <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_done  <= NREQ'(1) << grant;
                        rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_IDLE;
`ifdef APB_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // This is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
                        rsp_done  <= NREQ'(1) << grant;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt   <= tmo_cnt + TW'(1);
`endif
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
